// File: rtl/sync_fifo_nm_lanes.sv
// sync_fifo_nm_lanes: register FIFO with N parallel write lanes and M parallel read lanes
//   clk, rst_n            : clock, asynchronous active-low reset
//   flush                 : synchronous clear of pointers, count and error flags
//   data_in/wr_cnt        : write lanes (lane 0 oldest) and number of words offered
//   wr_space              : words that can be accepted this cycle
//   data_out/rd_cnt       : read lanes (lane 0 = head, zero latency) and words consumed
//   rd_avail              : valid read lanes this cycle
//   fill_cnt/afull/aempty : occupancy and threshold flags
//   overflow/underflow    : sticky error flags
module sync_fifo_nm_lanes #(
   parameter int DATA_WIDTH  = 8,
   parameter int FIFO_DEPTH  = 32,
   parameter int N           = 4,
   parameter int M           = 2,
   parameter int FIFO_AF_CNT = 24,
   parameter int FIFO_AE_CNT = 2,
   parameter int INIT_FIFO   = 0
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              flush,
   input  logic [N*DATA_WIDTH-1:0]           data_in,
   input  logic [$clog2(N+1)-1:0]            wr_cnt,
   output logic [$clog2(N+1)-1:0]            wr_space,
   output logic [M*DATA_WIDTH-1:0]           data_out,
   input  logic [$clog2(M+1)-1:0]            rd_cnt,
   output logic [$clog2(M+1)-1:0]            rd_avail,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fill_cnt,
   output logic                              afull,
   output logic                              aempty,
   output logic                              overflow,
   output logic                              underflow
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int WW = $clog2(N + 1);
   localparam int RW = $clog2(M + 1);
   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW:0] fill_x, free_x;
   logic [WW-1:0] wr_req, wr_acc;
   logic [RW-1:0] rd_req, rd_acc;
   // Counts are clamped to the lane count first, then to what the current state allows.
   always_comb begin
      fill_x   = {1'b0, fill_cnt};
      free_x   = (CW+1)'(FIFO_DEPTH) - fill_x;
      wr_space = free_x > (CW+1)'(N) ? WW'(N) : WW'(free_x);
      rd_avail = fill_x > (CW+1)'(M) ? RW'(M) : RW'(fill_x);
      wr_req   = wr_cnt > WW'(N) ? WW'(N) : wr_cnt;
      rd_req   = rd_cnt > RW'(M) ? RW'(M) : rd_cnt;
      wr_acc   = wr_req > wr_space ? wr_space : wr_req;
      rd_acc   = rd_req > rd_avail ? rd_avail : rd_req;
      afull    = fill_cnt >= CW'(FIFO_AF_CNT);
      aempty   = fill_cnt <= CW'(FIFO_AE_CNT);
      data_out = '0;
      for (int i = 0; i < M; i++)
         data_out[i*DATA_WIDTH +: DATA_WIDTH] = mem[rd_ptr + AW'(i)];
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         fill_cnt  <= INIT_FIFO != 0 ? CW'(FIFO_DEPTH) : '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++)
            mem[i] <= INIT_FIFO != 0 ? DATA_WIDTH'(i) : '0;
      end else if (flush) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         fill_cnt  <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         for (int i = 0; i < N; i++)
            if (WW'(i) < wr_acc)
               mem[wr_ptr + AW'(i)] <= data_in[i*DATA_WIDTH +: DATA_WIDTH];
         wr_ptr    <= wr_ptr + AW'(wr_acc);
         rd_ptr    <= rd_ptr + AW'(rd_acc);
         fill_cnt  <= CW'(fill_x + (CW+1)'(wr_acc) - (CW+1)'(rd_acc));
         overflow  <= overflow | (wr_req > wr_space);
         underflow <= underflow | (rd_req > rd_avail);
      end
endmodule

// File: doc/sync_fifo_nm_lanes.md
Name: sync_fifo_nm_lanes

Overview:
Register-based synchronous FIFO with N parallel write lanes and M parallel read lanes. Up to N words are pushed and up to M words popped per cycle, all in strict lane order. It provides clamped push/pop counts, explicit occupancy and free-space reporting, programmable almost-full/almost-empty thresholds, a synchronous flush, and sticky overflow/underflow error flags. It sits between width-mismatched streaming stages, for example a 4-word parser front end feeding a 2-word consumer.

Parameters:
DATA_WIDTH, 8, bits per word
FIFO_DEPTH, 32, entries; must be a power of 2 and >= max(N,M)
N, 4, write lanes; 1..FIFO_DEPTH
M, 2, read lanes; 1..FIFO_DEPTH
FIFO_AF_CNT, 24, afull asserts when fill_cnt >= this value
FIFO_AE_CNT, 2, aempty asserts when fill_cnt <= this value
INIT_FIFO, 0, 1 = after reset the FIFO is full and entry i holds i (truncated to DATA_WIDTH)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of pointers and count
data_in  input  N*DATA_WIDTH  write lanes; lane 0 is the oldest word
wr_cnt  input  $clog2(N+1)  number of words offered this cycle, 0..N
wr_space  output  $clog2(N+1)  words that can be accepted this cycle: min(FIFO_DEPTH-fill_cnt, N)
data_out  output  M*DATA_WIDTH  read lanes; lane 0 = head of FIFO
rd_cnt  input  $clog2(M+1)  number of words consumed this cycle, 0..M
rd_avail  output  $clog2(M+1)  valid read lanes this cycle: min(fill_cnt, M)
fill_cnt  output  $clog2(FIFO_DEPTH+1)  current occupancy
afull  output  1  fill_cnt >= FIFO_AF_CNT
aempty  output  1  fill_cnt <= FIFO_AE_CNT
overflow  output  1  sticky; set when wr_cnt > wr_space
underflow  output  1  sticky; set when rd_cnt > rd_avail

Behaviour:
- Storage: FIFO_DEPTH x DATA_WIDTH register array.
  - wr_ptr and rd_ptr are $clog2(FIFO_DEPTH) bits wide and wrap naturally modulo FIFO_DEPTH.
  - All lane address arithmetic (ptr+i) wraps the same way.
- Reset (rst_n low, asynchronous):
  - wr_ptr=0, rd_ptr=0.
  - fill_cnt=0, or FIFO_DEPTH if INIT_FIFO=1.
  - Array cleared to 0, or mem[i]=i if INIT_FIFO=1.
  - overflow=0, underflow=0.
  - All outputs are derived combinationally from this state and take their matching values.
- Accepted counts, computed from start-of-cycle state:
  - wr_acc = min(wr_cnt, wr_space); rd_acc = min(rd_cnt, rd_avail).
  - A pop in the same cycle does not create write space; a push in the same cycle does not create read data.
- Write: for i < wr_acc, mem[wr_ptr+i] <= data_in[i]. Lanes at or beyond wr_acc are discarded.
  - Next wr_ptr = wr_ptr + wr_acc.
- Read: data_out[i] = mem[rd_ptr+i], combinational with zero latency (FWFT).
  - Lanes with i >= rd_avail are don't-care; the bench must not check them.
  - Next rd_ptr = rd_ptr + rd_acc.
- Count: next fill_cnt = fill_cnt + wr_acc - rd_acc.
  - Compute in a width of $clog2(FIFO_DEPTH+1)+1 bits; the result never exceeds FIFO_DEPTH nor goes below 0.
- Errors:
  - overflow is set on any cycle with wr_cnt > wr_space.
  - underflow is set on any cycle with rd_cnt > rd_avail.
  - Both flags are cleared only by rst_n or flush.
  - An illegal wr_cnt > N is clamped to N before the overflow comparison.
  - An illegal rd_cnt > M is clamped to M before the underflow comparison.
- Flush (clk edge with flush=1):
  - wr_ptr=rd_ptr=0, fill_cnt=0, overflow=underflow=0.
  - Array contents are retained and not re-initialised, even when INIT_FIFO=1.
  - flush has priority over any concurrent wr_cnt or rd_cnt; no write occurs that cycle.
- Boundaries:
  - Full: wr_space=0, every write is dropped, overflow sets if wr_cnt>0.
  - Empty: rd_avail=0, underflow sets if rd_cnt>0.
  - Partial: with fill_cnt=FIFO_DEPTH-1 and wr_cnt=N, exactly one word (lane 0) is written.
- Ordering: the read order equals the write order across lanes and cycles, including across pointer wrap.

Test Plan:
- DEPTH=8, N=4, M=2. Write 4 words (A0..A3) and 4 words (A4..A7) in consecutive cycles -> fill_cnt=8, wr_space=0, afull=1 (AF=6). Then read 2/cycle for 4 cycles -> data_out pairs (A0,A1)..(A6,A7), then fill_cnt=0, aempty=1.
- fill_cnt=7, write wr_cnt=4 with B0..B3 -> only B0 stored, fill_cnt=8, overflow=1. overflow stays 1 after subsequent reads until flush.
- fill_cnt=1, rd_cnt=2 -> rd_avail=1, rd_ptr advances 1, fill_cnt=0, underflow=1.
- fill_cnt=8 (full), wr_cnt=4 and rd_cnt=2 in the same cycle -> nothing written, 2 read, fill_cnt=6. Next cycle wr_space=2.
- Wrap: 20 cycles of random wr_cnt/rd_cnt kept within limits -> a scoreboard matches every word in order; pointers wrap past 7 correctly.
- INIT_FIFO=1, release reset -> fill_cnt=8, data_out=(0,1). Assert flush -> fill_cnt=0, flags 0. Assert rst_n low mid-stream -> immediate return to the INIT state.
